read_arbiter: RTL and testbench
===============================

# read_arbiter

Round-robin arbiter that shares a single read-sequencer FSM (start/ws handshake, rd/ds outputs) among NUM_REQ requesters. It accepts one-hot request lines, grants exactly one requester at a time, and issues a one-cycle start pulse to the shared FSM. It waits for the FSM's ds (done) pulse, or for a watchdog timeout, then reports completion to the granted requester and rotates priority.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- TIMEOUT, 64: maximum cycles spent in WAIT before aborting. 0 disables the watchdog.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  level request per requester; bit i belongs to requester i.
- gnt  output  NUM_REQ  one-hot-or-zero grant, held from ISSUE through WAIT.
- done  output  NUM_REQ  one-cycle pulse on the winner's bit when ds is received.
- err  output  NUM_REQ  one-cycle pulse on the winner's bit on watchdog timeout.
- start  output  1  one-cycle start pulse to the shared read FSM.
- ds  input  1  done strobe from the shared read FSM.
- busy  output  1  high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, REL, held in a 2-bit state register.
- IDLE: when any req bit is high, the round-robin pick searches from ptr upward with wrap. The winner index is registered and the FSM moves to ISSUE. No req means it stays in IDLE.
- ISSUE: start=1 and gnt[win]=1. The FSM always moves to WAIT next. The timer is cleared.
- WAIT: gnt[win]=1.
  - If ds=1: go to REL with a done flag.
  - Else if TIMEOUT!=0 and timer==TIMEOUT-1: go to REL with an err flag.
  - Otherwise timer increments.
- REL: gnt=0. done[win] or err[win] pulses per the flag. ptr becomes (win+1) mod NUM_REQ. The FSM always moves to IDLE.
- ds and timeout in the same cycle: ds wins, and done pulses rather than err.
- ds outside WAIT: ignored, with no state change.
- A requester dropping req while granted is ignored, and the transaction completes. A requester must hold req until it sees done or err.
- After a pulse, a requester that keeps req high is re-arbitrated; the rotated pointer guarantees fairness.
- Timer width is $clog2(TIMEOUT+1), minimum 1. The timer saturates and never wraps.
- All outputs are decoded from registered state, win and flags only. There is no combinational path from req or ds to any output.
- Reset values: state=IDLE, ptr=0, win=0, timer=0, gnt=0, done=0, err=0, start=0, busy=0. Reset asserted mid-transaction aborts immediately, with no done or err pulse.

## Timing
- req[i] sampled high at edge k in IDLE: gnt[i]=1, start=1 and busy=1 during cycle k..k+1.
- start is high for exactly one cycle per grant.
- ds sampled high at edge m: REL occupies cycle m..m+1, with done[i]=1 and gnt=0.
- The state is IDLE at edge m+1. The earliest next start is in cycle m+2..m+3, so the shared FSM has returned to idle before it is restarted.
- Minimum per-transaction overhead is 3 cycles beyond the FSM's own latency (IDLE, ISSUE, REL).
- Timeout: err pulses TIMEOUT+1 cycles after start's cycle, i.e. in the REL cycle following the TIMEOUT-th WAIT cycle.

## Structure
- Package read_arb_pkg holds:
  - the typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REL} arb_state_t;
  - the localparam for the maximum NUM_REQ;
  - the function clog2_min1.
- Sub-module rr_picker (combinational):
  - inputs: req[NUM_REQ-1:0] and ptr.
  - outputs: valid and win index.
  - it is reused by future shared-resource arbiters.
- The top holds the FSM, the win/ptr/timer registers and the output flops.

## Test plan
- Single requester: after reset, req=4'b0010 -> gnt=4'b0010 and start for 1 cycle; ds 5 cycles later -> done=4'b0010 one cycle later; ptr=2.
- Fairness: req=4'b1111 held with ds returned each time -> grant order 0,1,2,3,0 and no requester granted twice in a row.
- Wrap: ptr=3 with req=4'b1001 -> grant 3, then 0.
- Timeout: TIMEOUT=8, ds never asserted -> err[win] pulses exactly 9 cycles after start, gnt drops, and the next request is served.
- ds and timeout coincide on the last WAIT cycle -> done pulses and err stays 0. A ds pulse while in IDLE -> no effect.
- Reset mid-op: rst_n low during WAIT -> all outputs 0 asynchronously; after release, req=4'b0100 -> grant 2 from ptr=0.

Source files
------------

// File: rtl/read_arb_pkg.sv
// Shared types and helpers for the read-sequencer arbiter and its picker.
package read_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REL} arb_state_t;

    localparam int MAX_NUM_REQ = 16;

    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request at or above ptr_i, with wrap.
module rr_picker
    import read_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIN_W   = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [WIN_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [WIN_W-1:0]   win_o
);

    int idx;

    // Scan from the farthest offset down so the nearest request to ptr_i wins.
    always_comb begin
        valid_o = 1'b0;
        win_o   = '0;
        idx     = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = int'(ptr_i) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_i[idx[WIN_W-1:0]]) begin
                valid_o = 1'b1;
                win_o   = idx[WIN_W-1:0];
            end
        end
    end

endmodule

// File: rtl/read_arbiter.sv
// Round-robin arbiter sharing one read-sequencer FSM among NUM_REQ requesters,
// with a watchdog on the sequencer's done strobe.
module read_arbiter
    import read_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] err,
    output logic               start,
    input  logic               ds,
    output logic               busy
);

    localparam int WIN_W = clog2_min1(NUM_REQ);
    localparam int TMR_W = clog2_min1(TIMEOUT + 1);
    localparam logic [WIN_W-1:0] WIN_MAX  = WIN_W'(NUM_REQ - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
        $error("read_arbiter: NUM_REQ out of range");
    end

    arb_state_t         state_q;
    logic [WIN_W-1:0]   win_q;
    logic [WIN_W-1:0]   ptr_q;
    logic [TMR_W-1:0]   timer_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] done_q;
    logic [NUM_REQ-1:0] err_q;
    logic               start_q;
    logic               busy_q;

    logic               pick_valid;
    logic [WIN_W-1:0]   pick_win;
    logic               timeout_hit;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .WIN_W   (WIN_W)
    ) u_picker (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .win_o   (pick_win)
    );

    assign timeout_hit = (TIMEOUT != 0) && (timer_q == TMR_LAST);

    function automatic logic [NUM_REQ-1:0] onehot(input logic [WIN_W-1:0] sel);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= '0;
            ptr_q   <= '0;
            timer_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        win_q   <= pick_win;
                        gnt_q   <= onehot(pick_win);
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // ds has priority over a timeout landing in the same cycle.
                    if (ds) begin
                        gnt_q   <= '0;
                        done_q  <= onehot(win_q);
                        state_q <= REL;
                    end else if (timeout_hit) begin
                        gnt_q   <= '0;
                        err_q   <= onehot(win_q);
                        state_q <= REL;
                    end else if (timer_q != '1) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                REL: begin
                    ptr_q   <= (win_q == WIN_MAX) ? '0 : win_q + 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign err   = err_q;
    assign start = start_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_read_arbiter.sv
// Randomised self-checking bench for read_arbiter against a round-robin reference model.
module tb_read_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] gnt, done, err;
    logic         start, ds, busy;

    int checks   = 0;
    int failures = 0;
    int exp_ptr  = 0;

    read_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt),
        .done  (done),
        .err   (err),
        .start (start),
        .ds    (ds),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Reference: first requester at or above the pointer, wrapping.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int o = 0; o < N; o++) begin
            if (r[(p + o) % N]) return (p + o) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] bit_of(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Cycle latency of the completion pulse, counted from the start cycle.
    function automatic int exp_lat(input int dsw);
        return (dsw <= TO) ? dsw + 1 : TO + 1;
    endfunction

    // Drives one transaction; ds is raised in the dsw-th cycle after start (never if dsw > TO).
    task automatic do_txn(input logic [N-1:0] r, input int dsw,
                          output logic [N-1:0] g, output logic b, output int starts,
                          output int lat, output logic [N-1:0] dn, output logic [N-1:0] er,
                          output logic [N-1:0] gp, output logic [N-1:0] post,
                          output logic post_busy);
        int c;
        req = r;
        @(posedge clk);
        @(negedge clk);
        g      = gnt;
        b      = busy;
        starts = start ? 1 : 0;
        lat    = -1;
        dn     = '0;
        er     = '0;
        gp     = '0;
        c      = 0;
        while (lat < 0 && c < 40) begin
            if (c == dsw) ds = 1'b1;
            @(negedge clk);
            c++;
            ds = 1'b0;
            if (start) starts++;
            if (done != '0 || err != '0) begin
                lat = c;
                dn  = done;
                er  = err;
                gp  = gnt;
            end
        end
        req = '0;
        @(negedge clk);
        post      = done | err;
        post_busy = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        ds    = 1'b0;
        #1;
        checks++; if (gnt !== '0)   begin failures++; $display("FAIL reset_gnt got=%b exp=0", gnt); end
        checks++; if (done !== '0)  begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (err !== '0)   begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", start); end
        checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        exp_ptr = 0;
        @(negedge clk);
    endtask

    // Generic transaction with all checks against the model.
    task automatic check_txn(input string name, input logic [N-1:0] r, input int dsw, output int won);
        logic [N-1:0] g, dn, er, gp, post;
        logic b, pb;
        int st, lat, ew;
        ew = pick(r, exp_ptr);
        do_txn(r, dsw, g, b, st, lat, dn, er, gp, post, pb);
        won = -1;
        for (int i = 0; i < N; i++) if (g == bit_of(i)) won = i;
        checks++; if (g !== bit_of(ew)) begin failures++; $display("FAIL %s_gnt got=%b exp=%b", name, g, bit_of(ew)); end
        checks++; if (b !== 1'b1) begin failures++; $display("FAIL %s_busy got=%b exp=1", name, b); end
        checks++; if (st != 1) begin failures++; $display("FAIL %s_start_count got=%0d exp=1", name, st); end
        checks++; if (lat != exp_lat(dsw)) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat(dsw)); end
        checks++; if (dn !== ((dsw <= TO) ? bit_of(ew) : '0)) begin failures++; $display("FAIL %s_done got=%b exp=%b", name, dn, (dsw <= TO) ? bit_of(ew) : 4'b0); end
        checks++; if (er !== ((dsw > TO) ? bit_of(ew) : '0)) begin failures++; $display("FAIL %s_err got=%b exp=%b", name, er, (dsw > TO) ? bit_of(ew) : 4'b0); end
        checks++; if (gp !== '0) begin failures++; $display("FAIL %s_gnt_in_rel got=%b exp=0", name, gp); end
        checks++; if (post !== '0 || pb !== 1'b0) begin failures++; $display("FAIL %s_after_pulse pulse=%b busy=%b exp=0/0", name, post, pb); end
        if (ew >= 0) exp_ptr = (ew + 1) % N;
    endtask

    task automatic test_fairness();
        int prev, w;
        int order[5] = '{0, 1, 2, 3, 0};
        prev = -1;
        for (int k = 0; k < 5; k++) begin
            check_txn("fair", 4'b1111, $urandom_range(1, 6), w);
            checks++; if (w != order[k]) begin failures++; $display("FAIL fair_order[%0d] got=%0d exp=%0d", k, w, order[k]); end
            checks++; if (w == prev) begin failures++; $display("FAIL fair_repeat got=%0d exp=not %0d", w, prev); end
            prev = w;
        end
    endtask

    task automatic test_single();
        int w;
        check_txn("single", 4'b0010, 5, w);
        checks++; if (exp_ptr != 2) begin failures++; $display("FAIL single_ptr got=%0d exp=2", exp_ptr); end
    endtask

    task automatic test_wrap();
        int w;
        check_txn("wrap_pre", 4'b0100, 2, w);
        check_txn("wrap_a", 4'b1001, 3, w);
        checks++; if (w != 3) begin failures++; $display("FAIL wrap_first got=%0d exp=3", w); end
        check_txn("wrap_b", 4'b1001, 1, w);
        checks++; if (w != 0) begin failures++; $display("FAIL wrap_second got=%0d exp=0", w); end
    endtask

    task automatic test_timeout();
        int w;
        check_txn("timeout", 4'b0100, 100, w);
        check_txn("after_to", 4'b0001, 2, w);
    endtask

    task automatic test_coincide();
        int w;
        check_txn("coincide", 4'b1000, TO, w);
    endtask

    task automatic test_ds_idle();
        int w;
        ds = 1'b1;
        @(negedge clk);
        ds = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || gnt !== '0 || done !== '0 || err !== '0 || start !== 1'b0) begin
            failures++; $display("FAIL ds_idle busy=%b gnt=%b done=%b err=%b start=%b exp=all 0", busy, gnt, done, err, start);
        end
        check_txn("post_ds_idle", 4'b1111, 3, w);
    endtask

    task automatic test_random();
        int w;
        for (int k = 0; k < 20; k++) begin
            check_txn("rand", 4'($urandom_range(1, 15)), $urandom_range(1, 12), w);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        req = 4'b1000;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        req = '0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (gnt !== '0 || busy !== 1'b0 || start !== 1'b0 || done !== '0 || err !== '0) begin
            failures++; $display("FAIL reset_mid gnt=%b busy=%b start=%b done=%b err=%b exp=all 0", gnt, busy, start, done, err);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ptr = 0;
        @(negedge clk);
        check_txn("after_rst", 4'b0100, 4, w);
        checks++; if (w != 2) begin failures++; $display("FAIL after_rst_win got=%0d exp=2", w); end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_wrap();
        test_timeout();
        test_coincide();
        test_ds_idle();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
